// File: rtl/neural_link_pkg.sv
// Shared definitions for the neural acquisition packet link.
// Holds the default sync word, packet field bit positions, the deframer
// state encoding and the packet checksum helper used by framer, deframer
// and benches.
package neural_link_pkg;

   localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

   localparam int unsigned PKT_SYNC_MSB = 63;
   localparam int unsigned PKT_SYNC_LSB = 56;
   localparam int unsigned PKT_CH_MSB   = 55;
   localparam int unsigned PKT_CH_LSB   = 52;
   localparam int unsigned PKT_DATA_MSB = 51;
   localparam int unsigned PKT_DATA_LSB = 36;
   localparam int unsigned PKT_SEQ_MSB  = 35;
   localparam int unsigned PKT_SEQ_LSB  = 20;
   localparam int unsigned PKT_CHK_MSB  = 7;
   localparam int unsigned PKT_CHK_LSB  = 0;

   typedef enum logic [0:0] {ST_HUNT, ST_LOCKED} deframer_state_e;

   // XOR of bytes [63:56] down to [15:8]; the low byte carries the result.
   function automatic logic [7:0] pkt_checksum(input logic [63:0] pkt);
      logic [7:0] acc;
      acc = '0;
      for (int unsigned i = 1; i < 8; i++) begin
         acc ^= pkt[i*8 +: 8];
      end
      return acc;
   endfunction

endpackage

// File: rtl/neural_packet_deframer_if.sv
// Packet-in / sample-out handshake bundle for the packet deframer.
//   master : packet source and sample sink (drives pkt_data, pkt_valid,
//            sample_ready; observes pkt_ready and the sample outputs)
//   slave  : the deframer (drives pkt_ready, sample_data, sample_channel,
//            sample_valid)
interface neural_packet_deframer_if #(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned CH_ID_WIDTH = 4
) ();

   logic [63:0]            pkt_data;
   logic                   pkt_valid;
   logic                   pkt_ready;
   logic [DATA_WIDTH-1:0]  sample_data;
   logic [CH_ID_WIDTH-1:0] sample_channel;
   logic                   sample_valid;
   logic                   sample_ready;

   modport master (
      output pkt_data, pkt_valid, sample_ready,
      input  pkt_ready, sample_data, sample_channel, sample_valid
   );

   modport slave (
      input  pkt_data, pkt_valid, sample_ready,
      output pkt_ready, sample_data, sample_channel, sample_valid
   );

endinterface

// File: rtl/neural_sat_counter.sv
// Saturating up-counter used for the deframer statistics.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : count up by one (holds at all-ones)
//   clr      : synchronous clear, wins over inc
//   count    : current value
module neural_sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/neural_packet_deframer.sv
// Receive-side packet deframer: validates sync word (and checksum when
// NEURAL_DEFRAMER_CHK_EN is defined), tracks the stream sequence number,
// runs a HUNT/LOCKED lock machine and forwards samples through a single
// registered valid/ready output stage.
//   out_clk, out_rst : clock, asynchronous active-high reset
//   link (slave)     : pkt_data/pkt_valid/pkt_ready in,
//                      sample_data/sample_channel/sample_valid/sample_ready out
//   locked           : lock machine is LOCKED
//   stat_clear       : synchronous clear of all statistics
//   stat_good        : forwarded packets
//   stat_sync_err    : sync-word mismatches
//   stat_chk_err     : checksum failures (0 when NEURAL_DEFRAMER_CHK_EN is undefined)
//   stat_seq_gap     : sequence discontinuities while locked
// Macro NEURAL_DEFRAMER_CHK_EN enables checksum verification.
module neural_packet_deframer
   import neural_link_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned CH_ID_WIDTH = 4,
   parameter logic [7:0]  SYNC_WORD   = SYNC_WORD_DEFAULT,
   parameter int unsigned LOCK_COUNT  = 4,
   parameter int unsigned LOSS_COUNT  = 3,
   parameter int unsigned STAT_WIDTH  = 16
) (
   input  logic                  out_clk,
   input  logic                  out_rst,
   neural_packet_deframer_if.slave link,
   output logic                  locked,
   input  logic                  stat_clear,
   output logic [STAT_WIDTH-1:0] stat_good,
   output logic [STAT_WIDTH-1:0] stat_sync_err,
   output logic [STAT_WIDTH-1:0] stat_chk_err,
   output logic [STAT_WIDTH-1:0] stat_seq_gap
);

   localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);
   localparam logic [3:0] LOSS_LAST = 4'(LOSS_COUNT - 1);

   deframer_state_e state, state_nxt;
   logic [3:0]  hunt_cnt, hunt_nxt;
   logic [3:0]  miss_cnt, miss_nxt;
   logic [15:0] exp_seq, exp_nxt;

   logic [63:0] pkt;
   logic [15:0] pkt_seq;
   logic        accept;
   logic        sync_ok;
   logic        chk_ok;
   logic        pkt_good;
   logic        fwd;
   logic        inc_gap;
   logic        inc_sync;

   logic                   sample_valid_q;
   logic [DATA_WIDTH-1:0]  sample_data_q;
   logic [CH_ID_WIDTH-1:0] sample_channel_q;

   assign pkt     = link.pkt_data;
   assign pkt_seq = pkt[PKT_SEQ_MSB:PKT_SEQ_LSB];

   // Single output register: accept whenever it is empty or draining this cycle.
   assign link.pkt_ready = !out_rst && (!sample_valid_q || link.sample_ready);
   assign accept         = link.pkt_valid && link.pkt_ready;

   assign sync_ok = (pkt[PKT_SYNC_MSB:PKT_SYNC_LSB] == SYNC_WORD);

`ifdef NEURAL_DEFRAMER_CHK_EN
   logic inc_chk;
   assign chk_ok  = (pkt_checksum(pkt) == pkt[PKT_CHK_MSB:PKT_CHK_LSB]);
   assign inc_chk = accept && sync_ok && !chk_ok;
`else
   logic unused_pkt_bits;
   assign chk_ok          = 1'b1;
   assign unused_pkt_bits = &{1'b0, pkt[19:0]};
`endif

   assign pkt_good = sync_ok && chk_ok;
   assign inc_sync = accept && !sync_ok;

   always_comb begin
      state_nxt = state;
      hunt_nxt  = hunt_cnt;
      miss_nxt  = miss_cnt;
      exp_nxt   = exp_seq;
      fwd       = 1'b0;
      inc_gap   = 1'b0;
      if (accept) begin
         if (state == ST_HUNT) begin
            if (pkt_good) begin
               exp_nxt = pkt_seq + 16'd1;
               if (hunt_cnt == LOCK_LAST) begin
                  state_nxt = ST_LOCKED;
                  hunt_nxt  = '0;
                  fwd       = 1'b1;
               end else begin
                  hunt_nxt = hunt_cnt + 4'd1;
               end
            end else begin
               hunt_nxt = '0;
            end
         end else begin
            if (pkt_good) begin
               fwd      = 1'b1;
               miss_nxt = '0;
               inc_gap  = (pkt_seq != exp_seq);
               exp_nxt  = pkt_seq + 16'd1;
            end else if (miss_cnt == LOSS_LAST) begin
               state_nxt = ST_HUNT;
               miss_nxt  = '0;
               hunt_nxt  = '0;
            end else begin
               miss_nxt = miss_cnt + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge out_clk or posedge out_rst) begin
      if (out_rst) begin
         state    <= ST_HUNT;
         hunt_cnt <= '0;
         miss_cnt <= '0;
         exp_seq  <= '0;
      end else begin
         state    <= state_nxt;
         hunt_cnt <= hunt_nxt;
         miss_cnt <= miss_nxt;
         exp_seq  <= exp_nxt;
      end
   end

   // A load always coincides with an empty or draining register, so the
   // load branch needs no ready qualification.
   always_ff @(posedge out_clk or posedge out_rst) begin
      if (out_rst) begin
         sample_valid_q   <= 1'b0;
         sample_data_q    <= '0;
         sample_channel_q <= '0;
      end else if (fwd) begin
         sample_valid_q   <= 1'b1;
         sample_data_q    <= DATA_WIDTH'(pkt[PKT_DATA_MSB:PKT_DATA_LSB]);
         sample_channel_q <= CH_ID_WIDTH'(pkt[PKT_CH_MSB:PKT_CH_LSB]);
      end else if (link.sample_ready) begin
         sample_valid_q <= 1'b0;
      end
   end

   assign link.sample_valid   = sample_valid_q;
   assign link.sample_data    = sample_data_q;
   assign link.sample_channel = sample_channel_q;
   assign locked              = (state == ST_LOCKED);

   neural_sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_good (
      .clk(out_clk), .rst(out_rst), .inc(fwd), .clr(stat_clear), .count(stat_good)
   );

   neural_sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_sync (
      .clk(out_clk), .rst(out_rst), .inc(inc_sync), .clr(stat_clear), .count(stat_sync_err)
   );

   neural_sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_gap (
      .clk(out_clk), .rst(out_rst), .inc(inc_gap), .clr(stat_clear), .count(stat_seq_gap)
   );

`ifdef NEURAL_DEFRAMER_CHK_EN
   neural_sat_counter #(.WIDTH(STAT_WIDTH)) u_stat_chk (
      .clk(out_clk), .rst(out_rst), .inc(inc_chk), .clr(stat_clear), .count(stat_chk_err)
   );
`else
   assign stat_chk_err = '0;
`endif

endmodule

// File: doc/neural_packet_deframer.md
Name: neural_packet_deframer

Overview:
- Receive-side counterpart of the acquisition packet framer and output FIFO. Consumes the 64-bit packet stream on the output clock domain using a valid/ready handshake.
- Validates sync word and checksum, tracks the per-stream sequence number, and runs a HUNT/LOCKED state machine.
- Emits per-sample channel and data through a registered valid/ready output.
- Used in the host-side link bridge and as the loopback checker in system benches.

Parameters:
- DATA_WIDTH, 16, sample width.
- CH_ID_WIDTH, 4, channel ID width.
- SYNC_WORD, 8'hA5, required value of packet bits [63:56].
- LOCK_COUNT, 4, consecutive good packets needed to enter LOCKED (range 1..15).
- LOSS_COUNT, 3, consecutive bad packets that drop LOCKED back to HUNT (range 1..15).
- STAT_WIDTH, 16, width of each saturating statistics counter.

Ports:
- out_clk  in  1  clock.
- out_rst  in  1  asynchronous, active-high reset.
- pkt_data  in  64  packet word.
- pkt_valid  in  1  packet word present.
- pkt_ready  out  1  deframer can accept a packet.
- sample_data  out  DATA_WIDTH  decoded sample.
- sample_channel  out  CH_ID_WIDTH  decoded channel ID.
- sample_valid  out  1  sample present.
- sample_ready  in  1  downstream accepts the sample.
- locked  out  1  state machine is LOCKED.
- stat_clear  in  1  synchronous clear of all stat_* counters.
- stat_good  out  STAT_WIDTH  count of forwarded packets.
- stat_sync_err  out  STAT_WIDTH  count of sync-word mismatches.
- stat_chk_err  out  STAT_WIDTH  count of checksum failures.
- stat_seq_gap  out  STAT_WIDTH  count of sequence discontinuities.

Behaviour:
- Packet format:
  - [63:56] sync
  - [55:52] channel
  - [51:36] sample
  - [35:20] seq (16 bits)
  - [19:8] reserved, ignored
  - [7:0] checksum = XOR of bytes [63:56] through [15:8]
- Reset (out_rst high, asynchronous):
  - state = HUNT; locked = 0; sample_valid = 0.
  - sample_data = 0; sample_channel = 0.
  - All stat_* = 0; hunt_cnt = 0; miss_cnt = 0; expected_seq = 0.
  - pkt_ready = 1 after reset deasserts.
- Reset mid-transfer discards any held sample. A packet presented during reset is not accepted.
- Accept condition: pkt_valid && pkt_ready.
  - pkt_ready = !sample_valid || sample_ready, i.e. a single output register with pass-through when drained.
  - pkt_ready has no combinational path from pkt_valid.
- Classification of an accepted packet:
  - sync_bad if sync != SYNC_WORD.
  - Otherwise chk_bad if checksum fails.
  - Otherwise good.
  - If sync_bad, only stat_sync_err increments.
- HUNT state:
  - good: hunt_cnt++, expected_seq = seq+1, packet not forwarded.
  - When hunt_cnt reaches LOCK_COUNT-1 and the current packet is good: go to LOCKED, locked = 1 next cycle, forward this packet, clear hunt_cnt.
  - bad: hunt_cnt = 0.
  - With LOCK_COUNT = 1, the first good packet locks and is forwarded.
- LOCKED state:
  - good: forward, miss_cnt = 0, stat_good++.
    - If seq != expected_seq, stat_seq_gap++.
    - expected_seq = seq+1 in all cases, wrapping 16'hFFFF to 0.
  - bad: not forwarded, miss_cnt++.
    - When miss_cnt reaches LOSS_COUNT: go to HUNT, locked = 0, miss_cnt = 0, hunt_cnt = 0.
- Forwarding:
  - sample_data and sample_channel load on the accept cycle, and sample_valid = 1 the next cycle (latency 1).
  - They hold stable while sample_valid && !sample_ready.
  - sample_valid deasserts on a handshake with no new load.
- Counters saturate at all-ones.
  - stat_clear wins over a same-cycle increment; the result is 0.
  - stat_clear does not affect state, lock, or the sample path.

Optional Feature:
- Macro: NEURAL_DEFRAMER_CHK_EN.
- Defined: checksum is verified as above; stat_chk_err is live.
- Undefined:
  - checksum byte is ignored.
  - good = sync match only.
  - stat_chk_err is tied to 0.
  - No XOR logic is synthesised.

Decomposition:
- Package neural_link_pkg holds:
  - SYNC_WORD default and packet field bit positions (PKT_SYNC_MSB/LSB, PKT_CH_*, PKT_DATA_*, PKT_SEQ_*, PKT_CHK_*).
  - typedef enum logic [0:0] {ST_HUNT, ST_LOCKED} deframer_state_e.
  - function pkt_checksum(logic [63:0]) returning 8 bits, shared with the framer and the benches.
- One sub-module: neural_sat_counter (width parameter; inc, clr inputs; clr priority), instantiated four times.

Test Plan:
- Reset, then 4 good packets (seq 0..3, ch 5, data 16'h1234): packets 0–2 not forwarded; packet 3 forwarded one cycle after accept; locked = 1; stat_good = 1.
- While locked, inject seq 4, 5, 9, 10: all forwarded; stat_seq_gap = 1; no gap counted on 10.
- While locked, 3 packets with sync 8'h5A: locked drops after the third; stat_sync_err = 3; none forwarded; then 4 good packets relock.
- While locked, 1 packet with a flipped checksum bit, then good: stat_chk_err = 1 with macro defined (0 and packet forwarded with macro undefined); locked stays 1.
- Hold sample_ready = 0 for 10 cycles with pkt_valid = 1: pkt_ready = 0 after the first accept; sample fields stable; exactly one packet consumed; no loss when released.
- Seq wrap 16'hFFFF→0: no gap. Counter saturation: force 16'hFFFF then +1 stays 16'hFFFF. stat_clear together with an increment gives 0. Assert out_rst mid-stream: sample_valid = 0 immediately.
